pref_queue: RTL

Prefetch issue queue directly downstream of the IP-stride prefetcher. Each cycle it accepts up to three prefetch candidates (slots 1, 2, 3 in priority order). It drops candidates whose cache line was recently queued, buffers the survivors in a FIFO, and issues them one per cycle to the memory side over a valid/ready handshake. Drops caused by a full queue are counted for performance analysis.

---
 rtl/pref_queue.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pref_queue.sv
// rtl/pref_queue.sv - prefetch issue queue with recent-line duplicate filter
//
// Accepts up to three prefetch candidates per cycle (slot 1 highest priority),
// drops recently queued lines (optional filter), buffers survivors in a FIFO
// and issues one line-aligned request per cycle over a valid/ready handshake.
// Candidates rejected for lack of space are counted in a saturating counter.
//
// Optional feature macro: PREF_QUEUE_FILTER_EN (recent-line filter plus
// in-cycle duplicate check). Without it, every valid candidate is queued if
// space allows.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pref_addrN_i/pref_validN_i candidate byte addresses and qualifiers, N=1..3
//   req_addr_o/req_valid_o     head-of-queue line-aligned address and valid
//   req_ready_i                downstream accept
//   count_o                    current occupancy
//   drop_cnt_o                 saturating count of space-limited drops
module pref_queue #(
  parameter int QUEUE_DEPTH     = 8,
  parameter int FILTER_SIZE     = 16,
  parameter int LOG2_BLOCK_SIZE = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [63:0]                      pref_addr1_i,
  input  logic [63:0]                      pref_addr2_i,
  input  logic [63:0]                      pref_addr3_i,
  input  logic                             pref_valid1_i,
  input  logic                             pref_valid2_i,
  input  logic                             pref_valid3_i,
  output logic [63:0]                      req_addr_o,
  output logic                             req_valid_o,
  input  logic                             req_ready_i,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] count_o,
  output logic [15:0]                      drop_cnt_o
);
  localparam int LW = 64 - LOG2_BLOCK_SIZE;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH+1);

  logic [LW-1:0] fifo_q [QUEUE_DEPTH];
  logic [LW-1:0] fifo_d [QUEUE_DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   drop_q, drop_d;

  logic [LW-1:0] cand_line [3];
  logic [2:0]    cand_vld;
  logic [1:0]    n_acc, n_drop;
  logic [CW-1:0] free_space;
  logic [PW-1:0] wr_idx;
  logic          dup, deq;
  logic [16:0]   drop_sum;

`ifdef PREF_QUEUE_FILTER_EN
  localparam int FW = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  logic [LW-1:0]          filt_line_q [FILTER_SIZE];
  logic [LW-1:0]          filt_line_d [FILTER_SIZE];
  logic [FILTER_SIZE-1:0] filt_vld_q, filt_vld_d;
  logic [FW-1:0]          filt_ptr_q, filt_ptr_d, filt_idx;
  logic [LW-1:0]          acc_line [3];
  logic [2:0]             acc_vld;
`endif

  assign cand_line[0] = pref_addr1_i[63:LOG2_BLOCK_SIZE];
  assign cand_line[1] = pref_addr2_i[63:LOG2_BLOCK_SIZE];
  assign cand_line[2] = pref_addr3_i[63:LOG2_BLOCK_SIZE];
  assign cand_vld     = {pref_valid3_i, pref_valid2_i, pref_valid1_i};

  // Byte offsets never matter: everything is tracked per cache line.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{pref_addr1_i[LOG2_BLOCK_SIZE-1:0],
                                pref_addr2_i[LOG2_BLOCK_SIZE-1:0],
                                pref_addr3_i[LOG2_BLOCK_SIZE-1:0]};

  assign req_valid_o = (count_q != '0);
  assign req_addr_o  = {fifo_q[head_q], {LOG2_BLOCK_SIZE{1'b0}}};
  assign count_o     = count_q;
  assign drop_cnt_o  = drop_q;
  assign deq         = req_valid_o && req_ready_i;

  always_comb begin
    fifo_d     = fifo_q;
    n_acc      = 2'd0;
    n_drop     = 2'd0;
    dup        = 1'b0;
    wr_idx     = tail_q;
    // Space is taken from the start-of-cycle occupancy; a dequeue in the same
    // cycle does not make room for this cycle's candidates.
    free_space = CW'(QUEUE_DEPTH) - count_q;
`ifdef PREF_QUEUE_FILTER_EN
    filt_line_d = filt_line_q;
    filt_vld_d  = filt_vld_q;
    filt_idx    = filt_ptr_q;
    acc_vld     = 3'b000;
    for (int k = 0; k < 3; k++) acc_line[k] = cand_line[k];
`endif
    for (int k = 0; k < 3; k++) begin
      dup = 1'b0;
`ifdef PREF_QUEUE_FILTER_EN
      // Filter lookup sees only pre-cycle contents; same-cycle inserts are
      // covered by the comparison against earlier accepted slots.
      for (int f = 0; f < FILTER_SIZE; f++) begin
        if (filt_vld_q[f] && (filt_line_q[f] == cand_line[k])) dup = 1'b1;
      end
      for (int j = 0; j < k; j++) begin
        if (acc_vld[j] && (acc_line[j] == cand_line[k])) dup = 1'b1;
      end
`endif
      if (cand_vld[k] && !dup) begin
        if (CW'(n_acc) < free_space) begin
          wr_idx         = tail_q + PW'(n_acc);
          fifo_d[wr_idx] = cand_line[k];
`ifdef PREF_QUEUE_FILTER_EN
          filt_idx              = filt_ptr_q + FW'(n_acc);
          filt_line_d[filt_idx] = cand_line[k];
          filt_vld_d[filt_idx]  = 1'b1;
          acc_vld[k]            = 1'b1;
`endif
          n_acc = n_acc + 2'd1;
        end else begin
          n_drop = n_drop + 2'd1;
        end
      end
    end
`ifdef PREF_QUEUE_FILTER_EN
    filt_ptr_d = filt_ptr_q + FW'(n_acc);
`endif
    tail_d   = tail_q + PW'(n_acc);
    head_d   = head_q + PW'(deq);
    count_d  = count_q + CW'(n_acc) - CW'(deq);
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) fifo_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
`ifdef PREF_QUEUE_FILTER_EN
      for (int i = 0; i < FILTER_SIZE; i++) filt_line_q[i] <= '0;
      filt_vld_q <= '0;
      filt_ptr_q <= '0;
`endif
    end else begin
      fifo_q  <= fifo_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
`ifdef PREF_QUEUE_FILTER_EN
      filt_line_q <= filt_line_d;
      filt_vld_q  <= filt_vld_d;
      filt_ptr_q  <= filt_ptr_d;
`endif
    end
  end
endmodule
